crc5_frame_sequencer: RTL and testbench

- Sequences a shared byte-wide CRC-5 engine for the I3C HDR-DDR path.
- Two requesters share the engine: TX framing and RX deserializer. Each presents 16-bit DDR data words.
- The block arbitrates per frame, splits each word into two bytes for the engine, waits out the engine latency, then returns the CRC.
- For RX frames it also compares the computed CRC against the received CRC.

---
 rtl/crc5_frame_sequencer.sv | 161 ++++++++++++++++
 tb/tb_crc5_frame_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc5_frame_sequencer.sv
// Per-frame arbiter and byte sequencer for a shared CRC-5 engine (TX framing vs RX deserializer).
// Optional stall timeout in S_FETCH is compiled in with `define CRC5_SEQ_TIMEOUT_EN.
module crc5_frame_sequencer #(
  parameter int CRC_LAT        = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic        i_tx_req,
  input  logic [15:0] i_tx_word,
  input  logic        i_tx_word_valid,
  input  logic        i_tx_last,
  output logic        o_tx_word_ready,
  output logic        o_tx_gnt,
  input  logic        i_rx_req,
  input  logic [15:0] i_rx_word,
  input  logic        i_rx_word_valid,
  input  logic        i_rx_last,
  output logic        o_rx_word_ready,
  output logic        o_rx_gnt,
  input  logic [4:0]  i_rx_crc,
  output logic        o_crc_clear,
  output logic [7:0]  o_crc_byte,
  output logic        o_crc_byte_valid,
  input  logic [4:0]  i_crc_value,
  output logic [4:0]  o_crc_value,
  output logic        o_crc_done,
  output logic        o_crc_owner,
  output logic        o_crc_err,
  output logic        o_crc_abort
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_HI    = 3'd3;
  localparam logic [2:0] S_LO    = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic OWN_TX = 1'b0;
  localparam logic OWN_RX = 1'b1;

  localparam logic [2:0] LAT_END = 3'((CRC_LAT > 0) ? (CRC_LAT - 1) : 0);

  logic [2:0]  r_state;
  logic        r_owner;
  logic        r_last_owner;
  logic [15:0] r_word;
  logic        r_last;
  logic [2:0]  r_wait_cnt;
  logic [4:0]  r_crc_value;
  logic        r_crc_err;

  logic        w_own_req;
  logic        w_own_vld;
  logic [15:0] w_own_word;
  logic        w_own_last;
  logic        w_in_frame;
  logic        w_timeout;
  logic        w_abort;
  logic        w_accept;
  logic        w_pick_rx;

  assign w_own_req  = (r_owner == OWN_RX) ? i_rx_req        : i_tx_req;
  assign w_own_vld  = (r_owner == OWN_RX) ? i_rx_word_valid : i_tx_word_valid;
  assign w_own_word = (r_owner == OWN_RX) ? i_rx_word       : i_tx_word;
  assign w_own_last = (r_owner == OWN_RX) ? i_rx_last       : i_tx_last;

  // Request drops only abandon the frame while words are still moving; S_WAIT/S_DONE always finish.
  assign w_in_frame = (r_state == S_FETCH) || (r_state == S_HI) || (r_state == S_LO);
  assign w_abort    = w_in_frame && (!w_own_req || w_timeout);
  assign w_accept   = (r_state == S_FETCH) && w_own_vld && !w_abort;
  assign w_pick_rx  = i_rx_req && (!i_tx_req || (r_last_owner == OWN_TX));

`ifdef CRC5_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_to_cnt <= '0;
    end else if ((r_state != S_FETCH) || w_accept) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_FETCH) && (r_to_cnt == TW'(TIMEOUT_CYCLES));
`else
  // No stall limit: the frame waits in S_FETCH for as long as the owner keeps requesting.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_TX;
      r_last_owner <= OWN_RX;
      r_word       <= '0;
      r_last       <= 1'b0;
      r_wait_cnt   <= '0;
      r_crc_value  <= '0;
      r_crc_err    <= 1'b0;
    end else if (w_abort) begin
      r_last_owner <= r_owner;
      r_state      <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_tx_req || i_rx_req) begin
            r_owner <= w_pick_rx;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: r_state <= S_FETCH;
        S_FETCH: begin
          if (w_accept) begin
            r_word  <= w_own_word;
            r_last  <= w_own_last;
            r_state <= S_HI;
          end
        end
        S_HI: r_state <= S_LO;
        S_LO: begin
          r_wait_cnt <= '0;
          if (!r_last)          r_state <= S_FETCH;
          else if (CRC_LAT == 0) r_state <= S_DONE;
          else                  r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_cnt == LAT_END) r_state <= S_DONE;
          else                       r_wait_cnt <= r_wait_cnt + 3'd1;
        end
        S_DONE: begin
          r_crc_value  <= i_crc_value;
          r_crc_err    <= (r_owner == OWN_RX) && (i_crc_value != i_rx_crc);
          r_last_owner <= r_owner;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_gnt         = (r_state != S_IDLE) && (r_owner == OWN_TX);
  assign o_rx_gnt         = (r_state != S_IDLE) && (r_owner == OWN_RX);
  assign o_tx_word_ready  = (r_state == S_FETCH) && (r_owner == OWN_TX) && !w_abort;
  assign o_rx_word_ready  = (r_state == S_FETCH) && (r_owner == OWN_RX) && !w_abort;
  assign o_crc_clear      = (r_state == S_CLEAR);
  assign o_crc_byte_valid = (r_state == S_HI) || (r_state == S_LO);
  assign o_crc_byte       = (r_state == S_HI) ? r_word[15:8] :
                            (r_state == S_LO) ? r_word[7:0]  : 8'h00;
  assign o_crc_done       = (r_state == S_DONE);
  assign o_crc_abort      = w_abort;
  assign o_crc_owner      = r_owner;
  assign o_crc_value      = r_crc_value;
  assign o_crc_err        = r_crc_err;

endmodule

// File: tb/tb_crc5_frame_sequencer.sv
// Scoreboard bench for crc5_frame_sequencer: expected done/abort events and byte strobes are queued
// as stimulus is driven and compared when the DUT produces them.
module tb_crc5_frame_sequencer;

  localparam int CRC_LAT = 1;
  localparam int TO_CYC  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_req = 1'b0, tx_vld = 1'b0, tx_last = 1'b0;
  logic [15:0] tx_word = '0;
  logic        rx_req = 1'b0, rx_vld = 1'b0, rx_last = 1'b0;
  logic [15:0] rx_word = '0;
  logic [4:0]  rx_crc = 5'h0A;
  logic [4:0]  crc_stub = 5'h0A;

  logic        tx_rdy, tx_gnt, rx_rdy, rx_gnt;
  logic        crc_clear, byte_vld, crc_done, crc_owner, crc_err, crc_abort;
  logic [7:0]  crc_byte;
  logic [4:0]  crc_value;

  crc5_frame_sequencer #(.CRC_LAT(CRC_LAT), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst_n),
    .i_tx_req(tx_req), .i_tx_word(tx_word), .i_tx_word_valid(tx_vld), .i_tx_last(tx_last),
    .o_tx_word_ready(tx_rdy), .o_tx_gnt(tx_gnt),
    .i_rx_req(rx_req), .i_rx_word(rx_word), .i_rx_word_valid(rx_vld), .i_rx_last(rx_last),
    .o_rx_word_ready(rx_rdy), .o_rx_gnt(rx_gnt), .i_rx_crc(rx_crc),
    .o_crc_clear(crc_clear), .o_crc_byte(crc_byte), .o_crc_byte_valid(byte_vld),
    .i_crc_value(crc_stub), .o_crc_value(crc_value), .o_crc_done(crc_done),
    .o_crc_owner(crc_owner), .o_crc_err(crc_err), .o_crc_abort(crc_abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       abort;
    logic       owner;
    logic [4:0] crc;
    logic       err;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] tx_bq[$];
  logic [7:0] rx_bq[$];
  int         done_cycs[$];
  int checks = 0, errors = 0;
  int cyc = 0, clr_cnt = 0, abort_cnt = 0, abort_cyc = 0, rx_gnt_rise = 0;
  logic       pend = 1'b0, prev_rx_gnt = 1'b0;
  ev_t        pend_ev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (pend) begin
      chk("done_value", 32'(crc_value), 32'(pend_ev.crc));
      chk("done_err", 32'(crc_err), 32'(pend_ev.err));
      pend = 1'b0;
    end
    if (crc_clear) clr_cnt++;
    if (rx_gnt && !prev_rx_gnt) rx_gnt_rise = cyc;
    prev_rx_gnt = rx_gnt;
    if (int'(crc_clear) + int'(crc_done) + int'(crc_abort) > 1) chk("pulse_excl", 0, 1);
    if (byte_vld) begin
      if (rx_gnt) begin
        if (rx_bq.size() == 0) chk("rx_byte_extra", 32'(crc_byte), 32'hFFFF);
        else chk("rx_byte", 32'(crc_byte), 32'(rx_bq.pop_front()));
      end else begin
        if (tx_bq.size() == 0) chk("tx_byte_extra", 32'(crc_byte), 32'hFFFF);
        else chk("tx_byte", 32'(crc_byte), 32'(tx_bq.pop_front()));
      end
    end
    if (crc_done || crc_abort) begin
      if (ev_q.size() == 0) begin
        chk("event_extra", 32'({crc_abort, crc_owner}), 32'hFFFF);
      end else begin
        e = ev_q.pop_front();
        chk("event_kind", 32'(crc_abort), 32'(e.abort));
        chk("event_owner", 32'(crc_owner), 32'(e.owner));
        if (crc_done) begin
          pend    = 1'b1;
          pend_ev = e;
          done_cycs.push_back(cyc);
        end else begin
          abort_cnt++;
          abort_cyc = cyc;
          chk("abort_value_hold", 32'(crc_value), 32'(e.crc));
          chk("abort_err_hold", 32'(crc_err), 32'(e.err));
        end
      end
    end
  end

  task automatic set_word(input bit rx, input logic [15:0] w, input bit last, input bit vld);
    if (rx) begin rx_word = w; rx_last = last; rx_vld = vld; end
    else    begin tx_word = w; tx_last = last; tx_vld = vld; end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the word.
  task automatic send_word(input bit rx, input logic [15:0] w, input bit last, output int acc_cyc);
    int budget = 0;
    acc_cyc = -1;
    set_word(rx, w, last, 1'b1);
    while (!(rx ? rx_rdy : tx_rdy) && budget < 300) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 300) begin
      chk("ready_timeout", 0, 1);
    end else begin
      acc_cyc = cyc;
      if (rx) begin rx_bq.push_back(w[15:8]); rx_bq.push_back(w[7:0]); end
      else    begin tx_bq.push_back(w[15:8]); tx_bq.push_back(w[7:0]); end
      @(posedge clk); #1;
    end
    set_word(rx, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic frame(input bit rx, input int n, input logic [15:0] w0, input logic [15:0] w1,
                       input bit drop, output int acc);
    int budget = 0;
    @(posedge clk); #1;
    if (rx) rx_req = 1'b1; else tx_req = 1'b1;
    for (int i = 0; i < n; i++) send_word(rx, (i == 0) ? w0 : w1, (i == n - 1), acc);
    while ((rx ? rx_gnt : tx_gnt) && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 100) chk("frame_end_timeout", 0, 1);
    if (drop) begin
      if (rx) rx_req = 1'b0; else tx_req = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
    chk("events_drained", 32'(ev_q.size()), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int acc, acc2, clr0;
    #1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_gnt", 32'(tx_gnt), 0);
    chk("rst_rx_gnt", 32'(rx_gnt), 0);
    chk("rst_ready", 32'({tx_rdy, rx_rdy}), 0);
    chk("rst_pulses", 32'({crc_clear, crc_done, crc_abort, byte_vld}), 0);
    chk("rst_byte", 32'(crc_byte), 0);
    chk("rst_value_err_owner", 32'({crc_value, crc_err, crc_owner}), 0);
    rst_n = 1'b1;

    // Two-word TX frame; the done cycle sits CRC_LAT+2 edges after the accepting edge.
    ev_q.push_back('{abort: 1'b0, owner: 1'b0, crc: 5'h0A, err: 1'b0});
    frame(1'b0, 2, 16'hA55A, 16'h0F3C, 1'b1, acc);
    settle();
    chk("tx_latency", 32'(done_cycs[done_cycs.size() - 1] - acc), 32'(CRC_LAT + 3));

    rx_crc = 5'h0B;
    ev_q.push_back('{abort: 1'b0, owner: 1'b1, crc: 5'h0A, err: 1'b1});
    frame(1'b1, 1, 16'h1234, 16'h0000, 1'b1, acc);
    settle();
    chk("rx_latency", 32'(done_cycs[done_cycs.size() - 1] - acc), 32'(CRC_LAT + 3));
    rx_crc = 5'h0A;
    ev_q.push_back('{abort: 1'b0, owner: 1'b1, crc: 5'h0A, err: 1'b0});
    frame(1'b1, 1, 16'h1234, 16'h0000, 1'b1, acc);
    settle();

    // Simultaneous requests after reset: TX, then RX, then RX has beaten TX's re-request.
    do_reset();
    done_cycs.delete();
    ev_q.push_back('{abort: 1'b0, owner: 1'b0, crc: 5'h0A, err: 1'b0});
    ev_q.push_back('{abort: 1'b0, owner: 1'b1, crc: 5'h0A, err: 1'b0});
    ev_q.push_back('{abort: 1'b0, owner: 1'b0, crc: 5'h0A, err: 1'b0});
    fork
      begin
        frame(1'b0, 1, 16'h1111, 16'h0000, 1'b0, acc);
        frame(1'b0, 1, 16'h3333, 16'h0000, 1'b1, acc);
      end
      frame(1'b1, 1, 16'h2222, 16'h0000, 1'b1, acc2);
    join
    settle();
    chk("rr_done_count", 32'(done_cycs.size()), 3);
    if (done_cycs.size() > 0) chk("rx_gnt_after_idle", 32'(rx_gnt_rise - done_cycs[0]), 2);

    // TX drops its request while its first word is being sent.
    ev_q.push_back('{abort: 1'b1, owner: 1'b0, crc: 5'h0A, err: 1'b0});
    @(posedge clk); #1;
    tx_req = 1'b1;
    send_word(1'b0, 16'hA55A, 1'b0, acc);
    tx_req = 1'b0;
    @(posedge clk); #1;
    tx_bq.delete();
    chk("abort_seen", 32'(abort_cnt), 1);
    chk("abort_gnt_low", 32'(tx_gnt), 0);
    clr0 = clr_cnt;
    ev_q.push_back('{abort: 1'b0, owner: 1'b1, crc: 5'h0A, err: 1'b0});
    frame(1'b1, 1, 16'hBEEF, 16'h0000, 1'b1, acc);
    settle();
    chk("clear_after_abort", 32'(clr_cnt - clr0), 1);

    // Asynchronous reset while the low byte is on the engine bus.
    @(posedge clk); #1;
    rx_req = 1'b1;
    send_word(1'b1, 16'h5678, 1'b1, acc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'({tx_gnt, rx_gnt}), 0);
    chk("arst_byte", 32'({byte_vld, crc_byte}), 0);
    chk("arst_value_err", 32'({crc_value, crc_err, crc_owner}), 0);
    chk("arst_pulses", 32'({crc_clear, crc_done, crc_abort}), 0);
    rx_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_bq.delete();
    rst_n = 1'b1;
    ev_q.push_back('{abort: 1'b0, owner: 1'b1, crc: 5'h0A, err: 1'b0});
    frame(1'b1, 2, 16'hCAFE, 16'hF00D, 1'b1, acc);
    settle();

`ifdef CRC5_SEQ_TIMEOUT_EN
    begin
      int fetch_cyc = 0, budget = 0, a0;
      a0 = abort_cnt;
      ev_q.push_back('{abort: 1'b1, owner: 1'b0, crc: 5'h0A, err: 1'b0});
      @(posedge clk); #1;
      tx_req = 1'b1;
      while (!tx_rdy && budget < 50) begin @(posedge clk); #1; budget++; end
      fetch_cyc = cyc;
      while (abort_cnt == a0 && budget < 100) begin @(posedge clk); #1; budget++; end
      tx_req = 1'b0;
      chk("timeout_abort_cycle", 32'(abort_cyc - fetch_cyc), 32'(TO_CYC));
      settle();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d exp 0", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
